// File: rtl/dbg_state_dumper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dbg_state_dumper_pkg                                            |
// | Brief  : Shared definitions for the debug state dumper. It holds the FSM |
// |          state encoding, the section flag constants and the terminal-    |
// |          index helper. The UART bridge reuses these definitions.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package dbg_state_dumper_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REG  = 3'd1,
    S_REQ_MEM = 3'd2,
    S_CAP_MEM = 3'd3,
    S_SEND    = 3'd4,
    S_DONE    = 3'd5
  } dump_state_e;

  // Section flag, which also appears on the stream as out_is_mem.
  localparam logic SEC_REG = 1'b0;
  localparam logic SEC_MEM = 1'b1;

  // The terminal test compares against the entry count, never against
  // counter wrap, so non-power-of-two NREGS/NMEM stop at the right word.
  function automatic logic is_last_idx(input int unsigned idx, input int unsigned count);
    return idx == (count - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_state_dumper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dbg_state_dumper_if                                             |
// | Brief  : Bundle of the dumper's read ports and output stream.            |
// |          master : dumper side (drives addresses, enable, beat payload)   |
// |          slave  : datapath/sink side (drives read data and out_ready)    |
// |   rf_raddr/rf_rdata   register-file read port (combinational read)       |
// |   dm_ren/dm_raddr/    data-memory read port (data valid the edge after   |
// |   dm_rdata            dm_ren)                                            |
// |   out_valid/out_ready/out_is_mem/out_index/out_data  beat stream         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface dbg_state_dumper_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dm_ren;
  logic [IDX_W-1:0]  dm_raddr;
  logic [DATA_W-1:0] dm_rdata;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_mem;
  logic [IDX_W-1:0]  out_index;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rf_raddr,
    input  rf_rdata,
    output dm_ren,
    output dm_raddr,
    input  dm_rdata,
    output out_valid,
    input  out_ready,
    output out_is_mem,
    output out_index,
    output out_data
  );

  modport slave (
    input  rf_raddr,
    output rf_rdata,
    input  dm_ren,
    input  dm_raddr,
    output dm_rdata,
    input  out_valid,
    output out_ready,
    input  out_is_mem,
    input  out_index,
    input  out_data
  );
endinterface
`default_nettype wire

// File: rtl/dbg_state_dumper_out_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dump_out_stage                                                  |
// | Brief  : Beat holding register for the dump stream. It loads a payload   |
// |          and raises valid. Valid clears on handshake or abort. The       |
// |          payload stays frozen until the next load.                       |
// |   clk, rst          clock, asynchronous active-high reset                |
// |   load_i            capture is_mem_i/index_i/data_i, raise valid         |
// |   hs_i              beat accepted by sink                                |
// |   abort_i           drop valid immediately (takes priority)              |
// |   valid_o, is_mem_o, index_o, data_o   registered beat                   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module dump_out_stage #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              is_mem_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              hs_i,
  input  logic              abort_i,
  output logic              valid_o,
  output logic              is_mem_o,
  output logic [IDX_W-1:0]  index_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q,  valid_d;
  logic              is_mem_q, is_mem_d;
  logic [IDX_W-1:0]  index_q,  index_d;
  logic [DATA_W-1:0] data_q,   data_d;

  always_comb begin
    valid_d  = valid_q;
    is_mem_d = is_mem_q;
    index_d  = index_q;
    data_d   = data_q;
    if (abort_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d  = 1'b1;
      is_mem_d = is_mem_i;
      index_d  = index_i;
      data_d   = data_i;
    end else if (hs_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      is_mem_q <= 1'b0;
      index_q  <= '0;
      data_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      is_mem_q <= is_mem_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end

  assign valid_o  = valid_q;
  assign is_mem_o = is_mem_q;
  assign index_o  = index_q;
  assign data_o   = data_q;

endmodule
`default_nettype wire

// File: rtl/dbg_state_dumper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dbg_state_dumper                                                |
// | Brief  : Read-side debug engine. A start pulse sweeps the register file  |
// |          and then data memory. The engine emits one {is_mem, index,      |
// |          data} beat per valid/ready handshake.                           |
// |   clk, rst     clock, asynchronous active-high reset                     |
// |   start_i      begin dump (sampled only in IDLE)                         |
// |   abort_i      synchronous cancel back to IDLE, no done pulse            |
// |   busy_o       high from the cycle after start until done completes      |
// |   done_o       one-cycle pulse after the last beat handshakes            |
// |   dump_if      read ports and beat stream (master modport)               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module dbg_state_dumper
  import dbg_state_dumper_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NMEM   = 32,
  parameter int IDX_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  dbg_state_dumper_if.master dump_if
);

  dump_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rf_raddr_q;
  logic [IDX_W-1:0] dm_raddr_q;
  logic             sec_q;
  logic             busy_q;
  logic             done_q;
  logic             dm_ren_q;

  logic              w_abort;
  logic              w_hs;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic              w_out_valid;
  logic              w_out_is_mem;
  logic [IDX_W-1:0]  w_out_index;
  logic [DATA_W-1:0] w_out_data;

  // abort only has an effect outside IDLE. It also beats a simultaneous start there.
  assign w_abort = abort_i && (state_q != S_IDLE);
  assign w_hs    = w_out_valid && dump_if.out_ready;

  // The register word is read combinationally in RD_REG. The memory word
  // arrives during CAP_MEM, from the read issued in REQ_MEM.
  assign w_load      = (state_q == S_RD_REG) || (state_q == S_CAP_MEM);
  assign w_load_data = (sec_q == SEC_MEM) ? dump_if.dm_rdata : dump_if.rf_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rf_raddr_q <= '0;
      dm_raddr_q <= '0;
      sec_q      <= SEC_REG;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dm_ren_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dm_ren_q <= 1'b0;
      if (w_abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              state_q    <= S_RD_REG;
              idx_q      <= '0;
              rf_raddr_q <= '0;
              sec_q      <= SEC_REG;
              busy_q     <= 1'b1;
            end
          end
          S_RD_REG:  state_q <= S_SEND;
          // dm_ren was raised on entry, so it is high for exactly this one cycle.
          S_REQ_MEM: state_q <= S_CAP_MEM;
          S_CAP_MEM: state_q <= S_SEND;
          S_SEND: begin
            if (w_hs) begin
              if (sec_q == SEC_REG) begin
                if (is_last_idx(32'(idx_q), NREGS)) begin
                  idx_q      <= '0;
                  sec_q      <= SEC_MEM;
                  state_q    <= S_REQ_MEM;
                  dm_ren_q   <= 1'b1;
                  dm_raddr_q <= '0;
                end else begin
                  idx_q      <= idx_q + IDX_W'(1);
                  rf_raddr_q <= idx_q + IDX_W'(1);
                  state_q    <= S_RD_REG;
                end
              end else begin
                if (is_last_idx(32'(idx_q), NMEM)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  idx_q      <= idx_q + IDX_W'(1);
                  dm_raddr_q <= idx_q + IDX_W'(1);
                  dm_ren_q   <= 1'b1;
                  state_q    <= S_REQ_MEM;
                end
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  dump_out_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_load),
    .is_mem_i (sec_q),
    .index_i  (idx_q),
    .data_i   (w_load_data),
    .hs_i     (w_hs),
    .abort_i  (w_abort),
    .valid_o  (w_out_valid),
    .is_mem_o (w_out_is_mem),
    .index_o  (w_out_index),
    .data_o   (w_out_data)
  );

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign dump_if.rf_raddr   = rf_raddr_q;
  assign dump_if.dm_ren     = dm_ren_q;
  assign dump_if.dm_raddr   = dm_raddr_q;
  assign dump_if.out_valid  = w_out_valid;
  assign dump_if.out_is_mem = w_out_is_mem;
  assign dump_if.out_index  = w_out_index;
  assign dump_if.out_data   = w_out_data;

endmodule
`default_nettype wire
